// File: rtl/in_fifo_pkg.sv
// Shared widths and bus types for the ten-channel nibble-in / byte-out FIFO.
package in_fifo_pkg;
    localparam int NUM_CH = 10;
    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [NUM_CH*NIB_W-1:0]  nib_bus_t;
    typedef logic [NUM_CH*BYTE_W-1:0] byte_bus_t;
endpackage

// File: rtl/in_fifo_nibble_pack.sv
// Pairs consecutive nibble writes into one byte per channel; the first nibble is the low half.
module in_fifo_nibble_pack
    import in_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      wren,
    input  nib_bus_t  d,
    output byte_bus_t byte_out,
    output logic      push
);
    logic     phase;
    nib_bus_t low;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase <= 1'b0;
            low   <= '0;
        end else if (wren) begin
            phase <= ~phase;
            if (!phase) low <= d;
        end
    end

    assign push = wren & phase;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign byte_out[ch*BYTE_W +: BYTE_W] = {d[ch*NIB_W +: NIB_W], low[ch*NIB_W +: NIB_W]};
    end
endmodule

// File: rtl/in_fifo_4x8.sv
// Ten-channel FIFO: nibble writes packed to bytes, byte reads with a registered Q.
// Optional sticky OVERFLOW/UNDERFLOW ports when IN_FIFO_ERR_FLAGS_EN is defined.
module in_fifo_4x8
    import in_fifo_pkg::*;
#(
    parameter int DEPTH              = 8,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1
) (
    input  logic      CLK,
    input  logic      RESETN,
    input  logic      WREN,
    input  nib_bus_t  D,
    input  logic      RDEN,
    output byte_bus_t Q,
    output logic      EMPTY,
    output logic      FULL,
    output logic      ALMOSTEMPTY,
    output logic      ALMOSTFULL
`ifdef IN_FIFO_ERR_FLAGS_EN
    ,
    output logic      OVERFLOW,
    output logic      UNDERFLOW
`endif
);
    localparam int AW = $clog2(DEPTH);

    byte_bus_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    byte_bus_t     wbyte;
    logic          push_req, do_push, do_pop;

    in_fifo_nibble_pack u_pack (
        .clk      (CLK),
        .resetn   (RESETN),
        .wren     (WREN),
        .d        (D),
        .byte_out (wbyte),
        .push     (push_req)
    );

    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign do_pop    = RDEN && !EMPTY;
    assign do_push   = push_req && (!FULL || do_pop);
    assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wbyte;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            Q           <= '0;
            EMPTY       <= 1'b1;
            FULL        <= 1'b0;
            ALMOSTEMPTY <= 1'b1;
            ALMOSTFULL  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                Q      <= mem[rd_ptr];
            end
            count       <= count_nxt;
            EMPTY       <= (count_nxt == '0);
            FULL        <= (count_nxt == (AW+1)'(DEPTH));
            ALMOSTEMPTY <= (count_nxt <= (AW+1)'(ALMOST_EMPTY_VALUE));
            ALMOSTFULL  <= (count_nxt >= (AW+1)'(DEPTH - ALMOST_FULL_VALUE));
        end
    end

`ifdef IN_FIFO_ERR_FLAGS_EN
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (push_req && !do_push) OVERFLOW  <= 1'b1;
            if (RDEN && EMPTY)        UNDERFLOW <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_in_fifo_4x8.sv
// Scoreboard bench for in_fifo_4x8: reference model predicts flags and queues expected bytes.
module tb_in_fifo_4x8;
    import in_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic      CLK = 1'b0;
    logic      RESETN = 1'b0;
    logic      WREN = 1'b0;
    logic      RDEN = 1'b0;
    nib_bus_t  D = '0;
    byte_bus_t Q;
    logic      EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL;
`ifdef IN_FIFO_ERR_FLAGS_EN
    logic      OVERFLOW, UNDERFLOW;
`endif

    in_fifo_4x8 dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .WREN        (WREN),
        .D           (D),
        .RDEN        (RDEN),
        .Q           (Q),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .ALMOSTEMPTY (ALMOSTEMPTY),
        .ALMOSTFULL  (ALMOSTFULL)
`ifdef IN_FIFO_ERR_FLAGS_EN
        ,
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW)
`endif
    );

    always #5 CLK = ~CLK;

    int        n_chk = 0;
    int        n_fail = 0;
    byte_bus_t sbq[$];
    byte_bus_t q_m;
    nib_bus_t  low_m;
    logic      phase_m, ovf_m, unf_m;
    int        cnt_m;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":Q"}, Q, q_m);
        chk({tag, ":EMPTY"}, 80'(EMPTY), 80'(cnt_m == 0));
        chk({tag, ":FULL"}, 80'(FULL), 80'(cnt_m == DEPTH));
        chk({tag, ":AEMPTY"}, 80'(ALMOSTEMPTY), 80'(cnt_m <= 1));
        chk({tag, ":AFULL"}, 80'(ALMOSTFULL), 80'(cnt_m >= DEPTH - 1));
`ifdef IN_FIFO_ERR_FLAGS_EN
        chk({tag, ":OVF"}, 80'(OVERFLOW), 80'(ovf_m));
        chk({tag, ":UNF"}, 80'(UNDERFLOW), 80'(unf_m));
`endif
    endtask

    // One clock: model updates before the edge, DUT sampled 1 time unit after it.
    task automatic step(input logic w, input nib_bus_t dv, input logic r, input string tag);
        logic      pop;
        byte_bus_t b;
        WREN = w; D = dv; RDEN = r;
        pop = r && (cnt_m > 0);
        if (r && cnt_m == 0) unf_m = 1'b1;
        if (pop) begin
            q_m = sbq.pop_front();
            cnt_m--;
        end
        if (w) begin
            if (phase_m) begin
                for (int c = 0; c < NUM_CH; c++)
                    b[c*8 +: 8] = {dv[c*4 +: 4], low_m[c*4 +: 4]};
                if (cnt_m < DEPTH) begin
                    sbq.push_back(b);
                    cnt_m++;
                end else begin
                    ovf_m = 1'b1;
                end
            end else begin
                low_m = dv;
            end
            phase_m = ~phase_m;
        end
        @(posedge CLK);
        #1;
        WREN = 1'b0; RDEN = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        RESETN = 1'b0; WREN = 1'b1; RDEN = 1'b1; D = '1;
        sbq.delete();
        cnt_m = 0; phase_m = 1'b0; low_m = '0; q_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESETN = 1'b1; WREN = 1'b0; RDEN = 1'b0;
        check_all(tag);
    endtask

    function automatic nib_bus_t rnd_nib();
        nib_bus_t v;
        for (int c = 0; c < NUM_CH; c++) v[c*4 +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    function automatic nib_bus_t fill_nib(input logic [3:0] n);
        return {NUM_CH{n}};
    endfunction

    initial begin
        do_reset("reset");

        // Pack and read one byte of 0x5A on every channel
        step(1'b1, fill_nib(4'hA), 1'b0, "pack_lo");
        step(1'b1, fill_nib(4'h5), 1'b0, "pack_hi");
        step(1'b0, '0, 1'b1, "read5a");
        chk("q_5a_ch0", 80'(Q[7:0]), 80'h5A);

        // Fill to FULL, then overflow with two extra nibbles, then drain in order
        for (int i = 0; i < 2*DEPTH; i++) step(1'b1, rnd_nib(), 1'b0, "fill");
        step(1'b1, rnd_nib(), 1'b0, "ovf_lo");
        step(1'b1, rnd_nib(), 1'b0, "ovf_hi");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain1");

        // Full with simultaneous push+pop
        for (int i = 0; i < 2*DEPTH; i++) step(1'b1, rnd_nib(), 1'b0, "refill");
        step(1'b1, rnd_nib(), 1'b0, "fullrw_lo");
        step(1'b1, rnd_nib(), 1'b1, "fullrw_hi");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain2");

        // Underflow: Q must hold
        step(1'b0, '0, 1'b1, "underflow");

        // Pointer wrap with mixed push/pop, including push+pop on non-empty
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rnd_nib(), 1'b0, "wrap_lo");
            step(1'b1, rnd_nib(), (i % 3) != 0, "wrap_hi");
            if (i % 2 == 0) step(1'b0, '0, 1'b1, "wrap_rd");
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, "wrap_drain");

        // Mid-pack reset drops the held nibble
        do_reset("reset2");
        step(1'b1, fill_nib(4'h7), 1'b0, "midpack");
        do_reset("reset3");
        step(1'b1, fill_nib(4'h3), 1'b0, "mp_lo");
        step(1'b1, fill_nib(4'hC), 1'b0, "mp_hi");
        step(1'b0, '0, 1'b1, "mp_read");
        chk("q_c3_ch9", 80'(Q[79:72]), 80'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
